// File: rtl/qnigma_arb.sv
// qnigma_arb -- registered N-channel arbiter with grant hold.
//
// Picks one requester by fixed-high, fixed-low or round-robin priority,
// holds the grant until the owner releases it (rel or dropping its req),
// then re-arbitrates in the same cycle so a waiting requester is granted
// on the next edge with no idle bubble. The released owner is masked out
// of that immediate re-arbitration.
//
// Parameters:
//   N    number of requesters (>= 2)
//   MODE 0 = highest index wins, 1 = lowest index wins, 2 = round-robin
//   HMAX maximum hold cycles per grant (>= 1), timeout build only
//
// Ports:
//   clk    clock
//   rst    synchronous reset, active-high
//   req    request vector, level-sensitive
//   rel    release strobe from the current owner
//   gnt    one-hot grant, registered
//   gnt_i  binary index of gnt, 0 when no grant
//   gnt_v  grant valid (|gnt)
//   tout   one-cycle pulse when a grant is revoked by hold timeout
//
// Build option: define QNIGMA_ARB_TIMEOUT_EN to add the hold-timeout
// counter; otherwise grants are held indefinitely and tout is 0.
//
// State | meaning
// IDLE  | no grant outstanding
// BUSY  | grant held by gnt_i

module qnigma_arb #(
  parameter int N    = 4,
  parameter int MODE = 2,
  parameter int HMAX = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 rel,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_i,
  output logic                 gnt_v,
  output logic                 tout
);

  localparam int IW = $clog2(N);

  if (N < 2 || HMAX < 1 || MODE < 0 || MODE > 2) begin : g_bad_param
    $error("qnigma_arb: need N >= 2, HMAX >= 1, MODE in 0..2");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [N-1:0]  gnt_n, cand;
  logic [IW-1:0] gnt_i_n, ptr, ptr_n, win_idx;
  logic          win_found, end_g, take, to_hit;

`ifdef QNIGMA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HMAX + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          tout_n;

  assign to_hit = (cnt == CW'(HMAX - 1));
`else
  assign to_hit = 1'b0;
  assign tout   = 1'b0;
`endif

  assign gnt_v = |gnt;

  // Winner search. While busy the owner's bit is masked so it cannot win
  // the arbitration that ends its own grant.
  always_comb begin
    int p;
    p         = int'(ptr);
    cand      = (state == BUSY) ? (req & ~gnt) : req;
    win_found = 1'b0;
    win_idx   = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
    end else if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--)
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
    end else begin
      // Walk from ptr upward; wrap by compare so non-power-of-two N works.
      for (int k = 0; k < N; k++) begin
        if (!win_found && cand[p]) begin
          win_found = 1'b1;
          win_idx   = IW'(p);
        end
        p = (p == N - 1) ? 0 : p + 1;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    gnt_i_n = gnt_i;
    ptr_n   = ptr;
    end_g   = 1'b0;
    take    = 1'b0;
`ifdef QNIGMA_ARB_TIMEOUT_EN
    cnt_n   = cnt;
    tout_n  = 1'b0;
`endif
    case (state)
      IDLE: take = win_found;
      BUSY: begin
        // rel, a dropped req and a timeout in the same cycle are one end.
        end_g = rel | ~req[gnt_i] | to_hit;
        if (end_g) begin
`ifdef QNIGMA_ARB_TIMEOUT_EN
          tout_n = to_hit & ~rel;
          cnt_n  = '0;
`endif
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            gnt_i_n = '0;
          end
        end else begin
`ifdef QNIGMA_ARB_TIMEOUT_EN
          cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
`endif
        end
      end
    endcase
    if (take) begin
      state_n = BUSY;
      gnt_n   = {{(N-1){1'b0}}, 1'b1} << win_idx;
      gnt_i_n = win_idx;
      ptr_n   = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
`ifdef QNIGMA_ARB_TIMEOUT_EN
      cnt_n   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      gnt_i <= '0;
      ptr   <= '0;
`ifdef QNIGMA_ARB_TIMEOUT_EN
      cnt   <= '0;
      tout  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      gnt_i <= gnt_i_n;
      ptr   <= ptr_n;
`ifdef QNIGMA_ARB_TIMEOUT_EN
      cnt   <= cnt_n;
      tout  <= tout_n;
`endif
    end
  end

endmodule

// File: tb/tb_qnigma_arb.sv
module tb_qnigma_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req4;
  logic       rel;
  logic [4:0] req5;
  logic       rel5;

  logic [3:0] gnt_m0, gnt_m1, gnt_m2;
  logic [1:0] gi_m0, gi_m1, gi_m2;
  logic       gv_m0, gv_m1, gv_m2;
  logic       to_m0, to_m1, to_m2;
  logic [4:0] gnt5;
  logic [2:0] gi5;
  logic       gv5, to5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qnigma_arb #(.N(4), .MODE(0), .HMAX(4)) u_m0 (
    .clk(clk), .rst(rst), .req(req4), .rel(rel),
    .gnt(gnt_m0), .gnt_i(gi_m0), .gnt_v(gv_m0), .tout(to_m0));
  qnigma_arb #(.N(4), .MODE(1), .HMAX(4)) u_m1 (
    .clk(clk), .rst(rst), .req(req4), .rel(rel),
    .gnt(gnt_m1), .gnt_i(gi_m1), .gnt_v(gv_m1), .tout(to_m1));
  qnigma_arb #(.N(4), .MODE(2), .HMAX(4)) u_m2 (
    .clk(clk), .rst(rst), .req(req4), .rel(rel),
    .gnt(gnt_m2), .gnt_i(gi_m2), .gnt_v(gv_m2), .tout(to_m2));
  qnigma_arb #(.N(5), .MODE(2), .HMAX(4)) u_n5 (
    .clk(clk), .rst(rst), .req(req5), .rel(rel5),
    .gnt(gnt5), .gnt_i(gi5), .gnt_v(gv5), .tout(to5));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req4 = '0;
    rel  = 1'b0;
    req5 = '0;
    rel5 = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({gnt_m0, gv_m0, gi_m0, to_m0} !== 8'b0) begin
        errors++;
        $display("FAIL reset_idle_m0 cyc %0d: got gnt=%b v=%b i=%0d tout=%b, want all 0",
                 i, gnt_m0, gv_m0, gi_m0, to_m0);
      end
      checks++;
      if ({gnt_m2, gv_m2, gi_m2, to_m2} !== 8'b0) begin
        errors++;
        $display("FAIL reset_idle_m2 cyc %0d: got gnt=%b v=%b i=%0d tout=%b, want all 0",
                 i, gnt_m2, gv_m2, gi_m2, to_m2);
      end
    end
  endtask

  task automatic test_mode0();
    do_reset();
    req4 = 4'b1010;
    cyc();
    checks++;
    if (gnt_m0 !== 4'b1000 || gi_m0 !== 2'd3 || gv_m0 !== 1'b1) begin
      errors++;
      $display("FAIL m0_first: got gnt=%b i=%0d v=%b, want 1000 3 1", gnt_m0, gi_m0, gv_m0);
    end
    rel = 1'b1;
    cyc();
    rel = 1'b0;
    checks++;
    if (gnt_m0 !== 4'b0010 || gi_m0 !== 2'd1) begin
      errors++;
      $display("FAIL m0_no_bubble: got gnt=%b i=%0d, want 0010 1", gnt_m0, gi_m0);
    end
    req4 = 4'b1110;
    cyc();
    checks++;
    if (gnt_m0 !== 4'b0010) begin
      errors++;
      $display("FAIL m0_hold_ignore: got gnt=%b, want 0010", gnt_m0);
    end
    req4 = 4'b1100;
    cyc();
    checks++;
    if (gnt_m0 !== 4'b1000 || gi_m0 !== 2'd3) begin
      errors++;
      $display("FAIL m0_drop_req: got gnt=%b i=%0d, want 1000 3", gnt_m0, gi_m0);
    end
  endtask

  task automatic test_release_mask();
    do_reset();
    req4 = 4'b1000;
    cyc();
    checks++;
    if (gnt_m0 !== 4'b1000) begin
      errors++;
      $display("FAIL mask_grant: got gnt=%b, want 1000", gnt_m0);
    end
    rel = 1'b1;
    cyc();
    rel = 1'b0;
    checks++;
    if (gnt_m0 !== 4'b0000 || gv_m0 !== 1'b0 || gi_m0 !== 2'd0) begin
      errors++;
      $display("FAIL mask_idle: got gnt=%b v=%b i=%0d, want 0000 0 0", gnt_m0, gv_m0, gi_m0);
    end
    cyc();
    checks++;
    if (gnt_m0 !== 4'b1000) begin
      errors++;
      $display("FAIL mask_regrant: got gnt=%b, want 1000", gnt_m0);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    req4 = 4'b1111;
    cyc();
    checks++;
    if (gnt_m0 !== 4'b1000 || gnt_m1 !== 4'b0001) begin
      errors++;
      $display("FAIL all_req_fixed: got m0=%b m1=%b, want 1000 0001", gnt_m0, gnt_m1);
    end
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (gnt_m2 !== exp || gi_m2 !== 2'(g % 4)) begin
          errors++;
          $display("FAIL rr_seq g%0d c%0d: got gnt=%b i=%0d, want %b %0d",
                   g, c, gnt_m2, gi_m2, exp, g % 4);
        end
        rel = (c == 2);
        cyc();
      end
    end
    rel = 1'b0;
  endtask

  task automatic test_mode1();
    do_reset();
    req4 = 4'b0101;
    cyc();
    checks++;
    if (gnt_m1 !== 4'b0001 || gi_m1 !== 2'd0) begin
      errors++;
      $display("FAIL m1_first: got gnt=%b i=%0d, want 0001 0", gnt_m1, gi_m1);
    end
    req4 = 4'b0100;
    cyc();
    checks++;
    if (gnt_m1 !== 4'b0100 || gi_m1 !== 2'd2) begin
      errors++;
      $display("FAIL m1_owner_drop: got gnt=%b i=%0d, want 0100 2", gnt_m1, gi_m1);
    end
    req4 = 4'b0011;
    rel  = 1'b1;
    cyc();
    rel  = 1'b0;
    checks++;
    if (gnt_m1 !== 4'b0001) begin
      errors++;
      $display("FAIL m1_rel_and_drop: got gnt=%b, want 0001", gnt_m1);
    end
    cyc();
    checks++;
    if (gnt_m1 !== 4'b0001) begin
      errors++;
      $display("FAIL m1_single_end: got gnt=%b, want 0001", gnt_m1);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (gnt_m1 !== 4'b0000 || gv_m1 !== 1'b0 || gi_m1 !== 2'd0) begin
      errors++;
      $display("FAIL m1_mid_reset: got gnt=%b v=%b i=%0d, want 0000 0 0", gnt_m1, gv_m1, gi_m1);
    end
    rst = 1'b0;
    req4 = 4'b0000;
  endtask

`ifdef QNIGMA_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req4 = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (gnt_m2 !== 4'b0001 || to_m2 !== 1'b0) begin
        errors++;
        $display("FAIL to_hold c%0d: got gnt=%b tout=%b, want 0001 0", c, gnt_m2, to_m2);
      end
    end
    cyc();
    checks++;
    if (gnt_m2 !== 4'b0010 || to_m2 !== 1'b1) begin
      errors++;
      $display("FAIL to_fire: got gnt=%b tout=%b, want 0010 1", gnt_m2, to_m2);
    end
    cyc();
    checks++;
    if (gnt_m2 !== 4'b0010 || to_m2 !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_len: got gnt=%b tout=%b, want 0010 0", gnt_m2, to_m2);
    end
    req4 = 4'b0000;
  endtask
`endif

  task automatic test_random();
    logic [4:0] rq, flip, prev;
    logic [2:0] exp_i;
    int         waitc[5];
    int         maxw;
    logic       newg;
    do_reset();
    prev = '0;
    for (int i = 0; i < 5; i++) waitc[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      flip = '0;
      for (int i = 0; i < 5; i++) flip[i] = ($urandom_range(0, 7) == 0);
      req5 = req5 ^ flip;
      rel5 = ($urandom_range(0, 3) == 0);
      rq   = req5;
      cyc();
      checks++;
      if ((gnt5 & (gnt5 - 5'd1)) !== 5'b0 || gv5 !== (gnt5 != 0)) begin
        errors++;
        $display("FAIL rnd_onehot n%0d: got gnt=%b v=%b", n, gnt5, gv5);
      end
      exp_i = '0;
      for (int i = 0; i < 5; i++) if (gnt5[i]) exp_i = 3'(i);
      checks++;
      if (gi5 !== exp_i) begin
        errors++;
        $display("FAIL rnd_index n%0d: got %0d, want %0d", n, gi5, exp_i);
      end
      newg = (gnt5 != 0) && (gnt5 != prev);
      maxw = 0;
      for (int i = 0; i < 5; i++) begin
        if (!rq[i] || gnt5[i]) waitc[i] = 0;
        else if (newg) waitc[i]++;
        if (waitc[i] > maxw) maxw = waitc[i];
      end
      checks++;
      if (maxw > 5) begin
        errors++;
        $display("FAIL rnd_starve n%0d: got wait=%0d grants, want <= 5", n, maxw);
      end
      prev = gnt5;
    end
    rel5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_release_mask();
    test_round_robin();
    test_mode1();
`ifdef QNIGMA_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
